pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the
//  hazard unit's load-use stall, EX-stage taken-branch flush, multi-cycle
//  mul/div occupancy and syscall halt into one lock/flush/bubble command set.
//  Drives the IF/ID/EX pipeline-register enables. Sits beside the hazard unit
//  in the ID/EX boundary logic.
// PARAMETERS
//  MD_LAT  32  front-end stall cycles per mul/div op (legal range 1..255)
//  CNT_W   16  width of stall performance counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous active-high reset
//  load_use    in   1      load-use hazard from hazard unit (ID stage)
//  branch_tk   in   1      taken branch/jump resolved in EX
//  md_start    in   1      mul/div instruction issuing in EX
//  halt_req    in   1      syscall halt in EX
//  resume      in   1      external resume from halt
//  lock_if     out  1      hold PC / IF-ID register
//  lock_id     out  1      hold ID-stage state
//  bubble_ex   out  1      load NOP into ID/EX register
//  flush_id    out  1      clear IF/ID register
//  md_busy     out  1      mul/div sequence in progress
//  md_done     out  1      one-cycle pulse, last mul/div stall cycle
//  halted      out  1      core in HALT state
//  stall_cnt   out  CNT_W  cycles with lock_if=1 (see CONFIGURATION)
// BEHAVIOUR
//  State reg: RUN, MD_WAIT, HALT; reset -> RUN. md_cnt is 8 bits, reset 0.
//  Reset: rst forces all outputs 0 combinationally in the rst cycle; state,
//   md_cnt, stall_cnt cleared at that edge; aborts MD_WAIT/HALT mid-operation.
//  EX events (halt_req/md_start/branch_tk) are mutually exclusive by design;
//   if violated, priority halt_req > md_start > branch_tk, losers ignored.
//  Outputs are combinational from state + inputs (zero-cycle latency).
//  RUN:
//   - branch_tk=1: flush_id=1, bubble_ex=1, lock_if=lock_id=0; load_use is
//     suppressed that cycle (wrong-path instruction).
//   - else load_use=1: lock_if=lock_id=bubble_ex=1 for that cycle only.
//   - md_start=1 at cycle T: md_cnt<=MD_LAT-1, state<=MD_WAIT; no lock at T;
//     load_use at T is still honoured.
//   - halt_req=1 at cycle T: state<=HALT; no lock at T.
//  MD_WAIT: lock_if=lock_id=bubble_ex=1, md_busy=1; all event inputs ignored;
//   md_cnt decrements each cycle; when md_cnt==0: md_done=1, state<=RUN.
//   Exactly MD_LAT stall cycles (T+1..T+MD_LAT); md_done at T+MD_LAT.
//   MD_LAT=1: single stall cycle, md_busy and md_done both high at T+1.
//  HALT: lock_if=lock_id=bubble_ex=1, halted=1; resume=1 -> RUN next edge
//   (still locked that cycle). resume in RUN/MD_WAIT is ignored.
//  flush_id is asserted only from RUN; never together with lock_if.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: stall_cnt increments each cycle lock_if=1,
//   saturates at 2^CNT_W-1, cleared only by rst.
//  Not defined: stall_cnt tied to 0, no counter flops synthesized.
// TESTING
//  1 load_use=1 one cycle in RUN -> lock_if=lock_id=bubble_ex=1 that cycle
//    only; flush_id=0.
//  2 branch_tk=1 with load_use=1 same cycle -> flush_id=1, bubble_ex=1,
//    lock_if=0.
//  3 MD_LAT=4, md_start at cycle 10 -> lock_if=1 cycles 11..14, md_done=1 at
//    14 only, md_busy=0 at 15; branch_tk at 12 ignored.
//  4 halt_req at 5, resume at 9 -> halted=1 cycles 6..9, lock_if=0 at 10.
//  5 rst at cycle 3 of MD_WAIT -> all outputs 0 in rst cycle, RUN afterwards,
//    md_done never pulses.
//  6 STALL_PERF_CNT_EN, CNT_W=4, 20 locked cycles -> stall_cnt=15 (saturated);
//    without macro stall_cnt=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. It merges the
//               load-use stall, the taken-branch flush, mul/div occupancy and
//               syscall halt into IF/ID/EX register controls.
//               Optional macro STALL_PERF_CNT_EN enables the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_tk,
    input  logic             md_start,
    input  logic             halt_req,
    input  logic             resume,
    output logic             lock_if,
    output logic             lock_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             md_busy,
    output logic             md_done,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [7:0] c_MD_INIT = 8'(MD_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_md_cnt;
    logic [7:0] w_md_cnt_nxt;

    logic w_lock;
    logic w_flush;
    logic w_md_busy;
    logic w_md_done;
    logic w_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Outputs stay zero for the whole reset cycle, regardless of state.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_lock       = 1'b0;
        w_flush      = 1'b0;
        w_md_busy    = 1'b0;
        w_md_done    = 1'b0;
        w_halted     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (halt_req) begin
                        w_state_nxt = S_HALT;
                    end else if (md_start) begin
                        w_state_nxt  = S_MD_WAIT;
                        w_md_cnt_nxt = c_MD_INIT;
                    end
                    // A taken branch only counts when no higher-priority EX event wins.
                    if (branch_tk && !halt_req && !md_start) begin
                        w_flush = 1'b1;
                    end else if (load_use) begin
                        w_lock = 1'b1;
                    end
                end
                S_MD_WAIT: begin
                    w_lock    = 1'b1;
                    w_md_busy = 1'b1;
                    if (r_md_cnt == 8'd0) begin
                        w_md_done   = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_md_cnt_nxt = r_md_cnt - 8'd1;
                    end
                end
                S_HALT: begin
                    w_lock   = 1'b1;
                    w_halted = 1'b1;
                    if (resume) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    assign lock_if   = w_lock;
    assign lock_id   = w_lock;
    assign bubble_ex = w_lock | w_flush;
    assign flush_id  = w_flush;
    assign md_busy   = w_md_busy;
    assign md_done   = w_md_done;
    assign halted    = w_halted;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_lock && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = rst ? '0 : r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed self-checking bench for pipeline_stall_ctrl
//               (MD_LAT=4, CNT_W=4); honours STALL_PERF_CNT_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

    localparam int c_CNT_W = 4;
`ifdef STALL_PERF_CNT_EN
    localparam int c_PERF = 1;
`else
    localparam int c_PERF = 0;
`endif

    // {lock_if, lock_id, bubble_ex, flush_id, md_busy, md_done, halted}
    localparam logic [6:0] c_IDLE  = 7'b000_0000;
    localparam logic [6:0] c_LOCK  = 7'b111_0000;
    localparam logic [6:0] c_FLUSH = 7'b001_1000;
    localparam logic [6:0] c_MDW   = 7'b111_0100;
    localparam logic [6:0] c_MDD   = 7'b111_0110;
    localparam logic [6:0] c_HALT  = 7'b111_0001;

    logic               clk;
    logic               rst;
    logic               load_use;
    logic               branch_tk;
    logic               md_start;
    logic               halt_req;
    logic               resume;
    logic               lock_if;
    logic               lock_id;
    logic               bubble_ex;
    logic               flush_id;
    logic               md_busy;
    logic               md_done;
    logic               halted;
    logic [c_CNT_W-1:0] stall_cnt;
    logic [6:0]         w_outs;

    int n_checks;
    int n_fail;

    pipeline_stall_ctrl #(
        .MD_LAT (4),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .load_use  (load_use),
        .branch_tk (branch_tk),
        .md_start  (md_start),
        .halt_req  (halt_req),
        .resume    (resume),
        .lock_if   (lock_if),
        .lock_id   (lock_id),
        .bubble_ex (bubble_ex),
        .flush_id  (flush_id),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    assign w_outs = {lock_if, lock_id, bubble_ex, flush_id, md_busy, md_done, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic [5:0] ins, input string tag, input logic [6:0] exp);
        {rst, load_use, branch_tk, md_start, halt_req, resume} = ins;
        @(negedge clk);
        check(tag, {25'd0, w_outs}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // input order: rst, load_use, branch_tk, md_start, halt_req, resume
    initial begin
        n_checks = 0;
        n_fail   = 0;
        {rst, load_use, branch_tk, md_start, halt_req, resume} = 6'b100000;
        @(posedge clk);
        #1;
        cyc(6'b110000, "reset_forces_zero", c_IDLE);
        check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        cyc(6'b000000, "idle_run", c_IDLE);

        cyc(6'b010000, "load_use_lock", c_LOCK);
        check("stall_cnt_after_one", {28'd0, stall_cnt}, (c_PERF != 0) ? 32'd1 : 32'd0);
        cyc(6'b000000, "load_use_one_cycle", c_IDLE);

        cyc(6'b011000, "branch_beats_load_use", c_FLUSH);
        cyc(6'b000000, "after_branch", c_IDLE);

        cyc(6'b010100, "md_start_load_use", c_LOCK);
        cyc(6'b000000, "md_wait_1", c_MDW);
        cyc(6'b001000, "md_wait_2_branch_ign", c_MDW);
        cyc(6'b000000, "md_wait_3", c_MDW);
        cyc(6'b000000, "md_done_4", c_MDD);
        cyc(6'b000000, "md_released", c_IDLE);

        cyc(6'b000010, "halt_req_no_lock", c_IDLE);
        cyc(6'b000000, "halted_1", c_HALT);
        cyc(6'b000000, "halted_2", c_HALT);
        cyc(6'b000000, "halted_3", c_HALT);
        cyc(6'b000001, "resume_still_locked", c_HALT);
        cyc(6'b000000, "after_resume", c_IDLE);

        cyc(6'b000001, "resume_in_run_ign", c_IDLE);
        cyc(6'b000000, "still_run", c_IDLE);

        cyc(6'b000110, "halt_beats_md", c_IDLE);
        cyc(6'b000000, "prio_halted", c_HALT);
        cyc(6'b000001, "prio_resume", c_HALT);

        cyc(6'b001100, "md_beats_branch", c_IDLE);
        cyc(6'b000000, "prio_md_1", c_MDW);
        cyc(6'b000000, "prio_md_2", c_MDW);
        cyc(6'b000000, "prio_md_3", c_MDW);
        cyc(6'b000000, "prio_md_done", c_MDD);
        check("stall_cnt_saturated_a", {28'd0, stall_cnt}, (c_PERF != 0) ? 32'd15 : 32'd0);

        cyc(6'b000100, "md_start_b", c_IDLE);
        cyc(6'b000000, "md_abort_w1", c_MDW);
        cyc(6'b000000, "md_abort_w2", c_MDW);
        cyc(6'b100000, "md_abort_rst", c_IDLE);
        check("rst_clears_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        cyc(6'b000000, "post_abort_1", c_IDLE);
        cyc(6'b000000, "post_abort_2", c_IDLE);
        cyc(6'b000000, "post_abort_3", c_IDLE);

        cyc(6'b000010, "halt_long", c_IDLE);
        for (int i = 0; i < 19; i++) begin
            cyc(6'b000000, "halt_long_locked", c_HALT);
        end
        cyc(6'b000001, "halt_long_resume", c_HALT);
        cyc(6'b000000, "halt_long_run", c_IDLE);
        check("stall_cnt_20_locked", {28'd0, stall_cnt}, (c_PERF != 0) ? 32'd15 : 32'd0);

        cyc(6'b000010, "halt_for_rst", c_IDLE);
        cyc(6'b000000, "halt_for_rst_h", c_HALT);
        cyc(6'b100000, "halt_rst", c_IDLE);
        cyc(6'b010000, "post_halt_rst_run", c_LOCK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
